// File: rtl/ic_rgbtoycbcr_convert_if.sv
// ic_rgbtoycbcr_convert_if: upstream FIFO read port plus downstream valid/ready pixel stream
interface ic_rgbtoycbcr_convert_if;
  logic ff_empty;
  logic [31:0] ff_q;
  logic ff_rdreq;
  logic [23:0] out_data;
  logic out_eol;
  logic out_valid;
  logic out_ready;
  modport master (input ff_empty, ff_q, out_ready, output ff_rdreq, out_data, out_eol, out_valid);
  modport slave (output ff_empty, ff_q, out_ready, input ff_rdreq, out_data, out_eol, out_valid);
endinterface

// File: rtl/ic_rgbtoycbcr_convert.sv
// ic_rgbtoycbcr_convert: RGB to JFIF YCbCr pipeline with credit-limited first-word-fall-through output buffer
module ic_rgbtoycbcr_convert #(
  parameter int OUT_DEPTH = 8,
  parameter int PIXELS_PER_LINE = 1920
) (
  input logic clock,
  input logic sclr,
  ic_rgbtoycbcr_convert_if.master io
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = PIXELS_PER_LINE > 1 ? $clog2(PIXELS_PER_LINE) : 1;
  localparam logic signed [8:0] COEF [9] = '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21};
  logic v1, v2, v3, pop, eol;
  logic signed [17:0] prod [9];
  logic signed [18:0] sum [3];
  logic [24:0] mem [OUT_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic [AW+1:0] credit;
  logic [CW-1:0] pix;
  function automatic logic [7:0] clamp(input logic signed [18:0] x);
    return x[18] ? 8'd0 : |x[17:16] ? 8'd255 : x[15:8];
  endfunction
  always_comb begin
    credit = {1'b0, occ} + (AW+2)'(v1) + (AW+2)'(v2) + (AW+2)'(v3);
    io.ff_rdreq = ~sclr & ~io.ff_empty & (credit < (AW+2)'(OUT_DEPTH));
    io.out_valid = ~sclr & (occ != '0);
    io.out_data = sclr ? '0 : mem[rp][23:0];
    io.out_eol = ~sclr & mem[rp][24];
    pop = io.out_valid & io.out_ready;
    eol = pix == CW'(PIXELS_PER_LINE - 1);
  end
  // v1 marks the cycle ff_q holds the requested pixel; the FIFO output register acts as the first stage
  always_ff @(posedge clock)
    if (sclr) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      pix <= '0;
    end else begin
      v1 <= io.ff_rdreq;
      v2 <= v1;
      v3 <= v2;
      for (int i = 0; i < 9; i++) prod[i] <= 18'($signed({1'b0, io.ff_q[23-8*(i%3) -: 8]})) * 18'(COEF[i]);
      for (int i = 0; i < 3; i++) sum[i] <= 19'(prod[3*i]) + 19'(prod[3*i+1]) + 19'(prod[3*i+2]) + (i == 0 ? 19'sd128 : 19'sd32896);
      if (v3) begin
        mem[wp] <= {eol, clamp(sum[0]), clamp(sum[1]), clamp(sum[2])};
        wp <= wp + AW'(1);
        pix <= eol ? '0 : pix + CW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      occ <= occ + (AW+1)'(v3) - (AW+1)'(pop);
    end
  no_overflow: assert property (@(posedge clock) disable iff (sclr) !(v3 && occ == (AW+1)'(OUT_DEPTH)));
endmodule
